// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the CONNECT 3x3 network endpoints.
// Holds the default field widths, the flit bit layout
// {valid, tail, dest, vc, data}, the credit width and the receive
// arbiter state type. No ports.
package noc_flit_pkg;

  localparam int FLIT_DATA_WIDTH = 64;
  localparam int DEST_BITS       = 4;
  localparam int VC_BITS         = 1;

  // Field offsets, counted from the LSB of the flit word.
  localparam int VC_LSB    = FLIT_DATA_WIDTH;
  localparam int DEST_LSB  = VC_LSB + VC_BITS;
  localparam int TAIL_BIT  = DEST_LSB + DEST_BITS;
  localparam int VALID_BIT = TAIL_BIT + 1;

  localparam int FLIT_WIDTH   = VALID_BIT + 1;
  localparam int CREDIT_WIDTH = 1 + VC_BITS;

  // ARB_HOLD keeps an offered but not yet accepted head flit on the
  // output, so a late arrival on another VC cannot replace it.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/flit_recv_endpoint_if.sv
// Valid/ready flit stream from the receive endpoint to the compute node.
//   msg_valid : flit available          (master -> slave)
//   msg_data  : flit payload            (master -> slave)
//   msg_last  : tail bit of the flit    (master -> slave)
//   msg_vc    : VC the flit arrived on  (master -> slave)
//   msg_ready : node accepts the flit   (slave -> master)
interface flit_recv_endpoint_if #(
  parameter int DATA_W = noc_flit_pkg::FLIT_DATA_WIDTH,
  parameter int VC_W   = noc_flit_pkg::VC_BITS
);

  logic              msg_valid;
  logic              msg_ready;
  logic [DATA_W-1:0] msg_data;
  logic              msg_last;
  logic [VC_W-1:0]   msg_vc;

  modport master (output msg_valid, msg_data, msg_last, msg_vc, input msg_ready);
  modport slave  (input msg_valid, msg_data, msg_last, msg_vc, output msg_ready);

endinterface

// File: rtl/flit_vc_fifo.sv
// Show-ahead FIFO holding the flits of one virtual channel.
//   clk, rst_n  : clock, async active-low reset
//   push_i      : write push_data_i (dropped when no room is left)
//   push_data_i : entry to store
//   pop_i       : discard the head entry (caller only pops when non-empty)
//   head_o      : current head entry, valid while !empty_o
//   empty_o     : no entries stored
//   full_o      : DEPTH entries stored
module flit_vc_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign push_ok = push_i && ((count_q - CNT_W'(pop_i)) < CNT_W'(DEPTH));

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // reset pointers/count, and the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: every sequential assignment is non-blocking so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_i);
    end
  end

endmodule

// File: rtl/flit_recv_endpoint.sv
// Receive-side network interface for one CONNECT receive port.
//   CLK, RST_N   : clock, async active-low reset
//   flit_in      : ejected flit {valid, tail, dest, vc, data}
//   credit_out   : {valid, vc}, one cycle per dequeued flit
//   credit_en    : copy of the credit_out valid bit
//   overflow_err : sticky, a flit hit a full VC buffer and was dropped
//   dest_err     : sticky, a flit carried a dest other than MY_ID
//   msg          : valid/ready stream to the compute node
module flit_recv_endpoint #(
  parameter int FLIT_DATA_WIDTH = noc_flit_pkg::FLIT_DATA_WIDTH,
  parameter int DEST_BITS       = noc_flit_pkg::DEST_BITS,
  parameter int VC_BITS         = noc_flit_pkg::VC_BITS,
  parameter int NUM_VCS         = 2,
  parameter int BUF_DEPTH       = 4,
  parameter int MY_ID           = 0
) (
  input  logic                                       CLK,
  input  logic                                       RST_N,
  input  logic [FLIT_DATA_WIDTH+DEST_BITS+VC_BITS+1:0] flit_in,
  output logic [VC_BITS:0]                           credit_out,
  output logic                                       credit_en,
  output logic                                       overflow_err,
  output logic                                       dest_err,
  flit_recv_endpoint_if.master                       msg
);

  import noc_flit_pkg::*;

  localparam int IN_VC_LSB    = FLIT_DATA_WIDTH;
  localparam int IN_DEST_LSB  = IN_VC_LSB + VC_BITS;
  localparam int IN_TAIL_BIT  = IN_DEST_LSB + DEST_BITS;
  localparam int IN_VALID_BIT = IN_TAIL_BIT + 1;
  localparam int ENTRY_W      = FLIT_DATA_WIDTH + 1;  // {tail, data}

  // Incoming flit fields.
  logic                       in_valid;
  logic                       in_tail;
  logic [DEST_BITS-1:0]       in_dest;
  logic [VC_BITS-1:0]         in_vc;
  logic [FLIT_DATA_WIDTH-1:0] in_data;

  assign in_valid = flit_in[IN_VALID_BIT];
  assign in_tail  = flit_in[IN_TAIL_BIT];
  assign in_dest  = flit_in[IN_DEST_LSB +: DEST_BITS];
  assign in_vc    = flit_in[IN_VC_LSB +: VC_BITS];
  assign in_data  = flit_in[FLIT_DATA_WIDTH-1:0];

  // Per-VC buffers.
  logic [NUM_VCS-1:0] push;
  logic [NUM_VCS-1:0] pop;
  logic [NUM_VCS-1:0] empty;
  logic [NUM_VCS-1:0] full;
  logic [NUM_VCS-1:0] drop;
  logic [ENTRY_W-1:0] head [NUM_VCS];

  // Arbiter state and selection.
  arb_state_e         state_q;
  logic [VC_BITS-1:0] lock_vc_q;
  logic [VC_BITS-1:0] rr_ptr_q;
  logic [VC_BITS-1:0] sel_vc;
  logic               sel_found;
  logic [ENTRY_W-1:0] sel_entry;
  logic               do_pop;

  logic [VC_BITS:0]   credit_q;
  logic               overflow_q;
  logic               dest_err_q;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v] = in_valid && (in_vc == VC_BITS'(v));
    assign pop[v]  = do_pop && (sel_vc == VC_BITS'(v));
    assign drop[v] = push[v] && full[v] && !pop[v];

    flit_vc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk         (CLK),
      .rst_n       (RST_N),
      .push_i      (push[v]),
      .push_data_i ({in_tail, in_data}),
      .pop_i       (pop[v]),
      .head_o      (head[v]),
      .empty_o     (empty[v]),
      .full_o      (full[v])
    );
  end

  // Outside IDLE only the owning VC may be presented; in IDLE the first
  // non-empty VC at or after the round-robin pointer wins.
  // NOTE: both outputs get a default first, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    sel_vc    = lock_vc_q;
    sel_found = 1'b0;
    if (state_q != ARB_IDLE) begin
      sel_found = !empty[lock_vc_q];
    end else begin
      for (int i = 0; i < NUM_VCS; i++) begin
        if (!sel_found && !empty[rr_ptr_q + VC_BITS'(i)]) begin
          sel_vc    = rr_ptr_q + VC_BITS'(i);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign sel_entry = head[sel_vc];
  assign do_pop    = sel_found && msg.msg_ready;

  // Fields are forced to zero while nothing is offered, which also gives
  // the all-zero output during and right after reset.
  assign msg.msg_valid = sel_found;
  assign msg.msg_data  = sel_found ? sel_entry[FLIT_DATA_WIDTH-1:0] : '0;
  assign msg.msg_last  = sel_found && sel_entry[FLIT_DATA_WIDTH];
  assign msg.msg_vc    = sel_found ? sel_vc : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ARB_IDLE;
      lock_vc_q  <= '0;
      rr_ptr_q   <= '0;
      credit_q   <= '0;
      overflow_q <= 1'b0;
      dest_err_q <= 1'b0;
    end else begin
      credit_q <= '0;
      if (do_pop) begin
        credit_q <= {1'b1, sel_vc};
        rr_ptr_q <= sel_vc + 1'b1;
        if (sel_entry[FLIT_DATA_WIDTH]) begin
          state_q <= ARB_IDLE;
        end else begin
          state_q   <= ARB_LOCKED;
          lock_vc_q <= sel_vc;
        end
      end else if (state_q == ARB_IDLE && sel_found) begin
        state_q   <= ARB_HOLD;
        lock_vc_q <= sel_vc;
      end

      if (|drop) overflow_q <= 1'b1;
      if (in_valid && (in_dest != DEST_BITS'(MY_ID))) dest_err_q <= 1'b1;
    end
  end

  assign credit_out   = credit_q;
  assign credit_en    = credit_q[VC_BITS];
  assign overflow_err = overflow_q;
  assign dest_err     = dest_err_q;

endmodule
